// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sequencer
//  Description : Four-state instruction sequencer. It accepts one 16-bit
//                instruction, reads operands from an internal 8 x 16
//                register file, drives an external combinational ALU,
//                captures the result and writes it back. One instruction
//                retires every four cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DBG_EN         1 = debug read port active, 0 = dbg_data tied to zero
//  Ports
//    clk            clock, rising-edge active
//    rst            synchronous active-high reset
//    instr_valid    instruction offered
//    instr_ready    sequencer idle and able to accept an instruction
//    instr[15:0]    instruction word {op[2:0], rd[2:0], ra[2:0], rb/imm7}
//    alu_op_a       registered operand A to the ALU
//    alu_op_b       registered operand B to the ALU
//    alu_op_select  registered ALU operation code
//    alu_result     combinational ALU result
//    done           one-cycle pulse at instruction retirement
//    illegal        one-cycle pulse together with done for opcodes 110/111
//    wb_data        value written back, held until replaced
//    busy           high whenever the sequencer is not idle
//    dbg_addr       debug register-file read address
//    dbg_data       combinational register-file read data
// ============================================================================
module exec_sequencer #(
  parameter bit DBG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_op_a,
  output logic [15:0] alu_op_b,
  output logic [2:0]  alu_op_select,
  input  logic [15:0] alu_result,
  output logic        done,
  output logic        illegal,
  output logic [15:0] wb_data,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] c_op_pass_a = 3'b011;
  localparam logic [2:0] c_op_pass_b = 3'b100;
  localparam logic [2:0] c_op_ldi    = 3'b101;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t       state_q,   state_d;
  logic [15:0]  instr_q,   instr_d;
  logic [15:0]  op_a_q,    op_a_d;
  logic [15:0]  op_b_q,    op_b_d;
  logic [2:0]   op_sel_q,  op_sel_d;
  logic [15:0]  wb_q,      wb_d;
  logic         done_q,    done_d;
  logic         illegal_q, illegal_d;
  logic [15:0]  rf_q [8];
  logic [15:0]  rf_d [8];

  // --------------------------------------------------------------------------
  // Decode of the latched instruction
  // --------------------------------------------------------------------------
  logic [2:0]  w_opcode;
  logic [2:0]  w_rd;
  logic [2:0]  w_ra;
  logic [2:0]  w_rb;
  logic [6:0]  w_imm7;
  logic        w_is_illegal;
  logic [15:0] w_reg_a;
  logic [15:0] w_reg_b;

  assign w_opcode     = instr_q[15:13];
  assign w_rd         = instr_q[12:10];
  assign w_ra         = instr_q[9:7];
  assign w_rb         = instr_q[6:4];
  assign w_imm7       = instr_q[6:0];
  assign w_is_illegal = w_opcode[2] & w_opcode[1];

  // r0 is hard-wired to zero on every read path.
  assign w_reg_a = (w_ra == 3'd0) ? 16'h0000 : rf_q[w_ra];
  assign w_reg_b = (w_rb == 3'd0) ? 16'h0000 : rf_q[w_rb];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_sel_d  = op_sel_q;
    wb_d      = wb_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
    end

    unique case (state_q)
      ST_IDLE: begin
        // Reset priority over acceptance is enforced in the register block.
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (w_is_illegal) begin
          // Illegal opcodes run a harmless PASS_A of zero through the ALU.
          op_a_d   = 16'h0000;
          op_b_d   = 16'h0000;
          op_sel_d = c_op_pass_a;
        end else if (w_opcode == c_op_ldi) begin
          // LDI reuses PASS_B with the zero-extended immediate on port B.
          op_a_d   = w_reg_a;
          op_b_d   = {9'b0, w_imm7};
          op_sel_d = c_op_pass_b;
        end else begin
          op_a_d   = w_reg_a;
          op_b_d   = w_reg_b;
          op_sel_d = w_opcode;
        end
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        wb_d    = alu_result;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        if (!w_is_illegal && (w_rd != 3'd0)) begin
          rf_d[w_rd] = wb_q;
        end
        done_d    = 1'b1;
        illegal_d = w_is_illegal;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= 16'h0000;
      op_a_q    <= 16'h0000;
      op_b_q    <= 16'h0000;
      op_sel_q  <= 3'b000;
      wb_q      <= 16'h0000;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sel_q  <= op_sel_d;
      wb_q      <= wb_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_ready   = (state_q == ST_IDLE) && !rst;
  assign busy          = (state_q != ST_IDLE);
  assign alu_op_a      = op_a_q;
  assign alu_op_b      = op_b_q;
  assign alu_op_select = op_sel_q;
  assign wb_data       = wb_q;
  assign done          = done_q;
  assign illegal       = illegal_q;

  generate
    if (DBG_EN) begin : g_dbg
      assign dbg_data = rf_q[dbg_addr];
    end else begin : g_no_dbg
      assign dbg_data = 16'h0000;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_sequencer
//  Description : Directed self-checking bench for exec_sequencer. A small
//                reference model of the register file predicts each
//                retirement; predictions are queued at issue and compared
//                when done pulses. The bench also supplies the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_op_a;
  logic [15:0] alu_op_b;
  logic [2:0]  alu_op_select;
  logic [15:0] alu_result;
  logic        done;
  logic        illegal;
  logic [15:0] wb_data;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  exec_sequencer #(.DBG_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_op_a      (alu_op_a),
    .alu_op_b      (alu_op_b),
    .alu_op_select (alu_op_select),
    .alu_result    (alu_result),
    .done          (done),
    .illegal       (illegal),
    .wb_data       (wb_data),
    .busy          (busy),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op_select)
      3'b000:  alu_result = alu_op_a + alu_op_b;
      3'b001:  alu_result = alu_op_a - alu_op_b;
      3'b010:  alu_result = ~(alu_op_a & alu_op_b);
      3'b011:  alu_result = alu_op_a;
      3'b100:  alu_result = alu_op_b;
      default: alu_result = 16'h0000;
    endcase
  end

  typedef struct packed {
    logic [15:0] wb;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mreg [8];
  int          passed;
  int          total;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] encode(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [6:0] low);
    return {op, rd, ra, low};
  endfunction

  // Reference model: predict the retirement and update the model registers.
  task automatic predict(input logic [15:0] ins);
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
    op = ins[15:13];
    rd = ins[12:10];
    a  = (ins[9:7] == 3'd0) ? 16'h0000 : mreg[ins[9:7]];
    b  = (ins[6:4] == 3'd0) ? 16'h0000 : mreg[ins[6:4]];
    e.ill = 1'b0;
    case (op)
      3'b000:  e.wb = a + b;
      3'b001:  e.wb = a - b;
      3'b010:  e.wb = ~(a & b);
      3'b011:  e.wb = a;
      3'b100:  e.wb = b;
      3'b101:  e.wb = {9'b0, ins[6:0]};
      default: begin e.wb = 16'h0000; e.ill = 1'b1; end
    endcase
    if (!e.ill && rd != 3'd0) mreg[rd] = e.wb;
    sb_q.push_back(e);
  endtask

  task automatic compare_retire(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 16'(done), 16'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_wb"}, wb_data, e.wb);
      check({tag, "_illegal"}, 16'(illegal), 16'(e.ill));
    end
  endtask

  task automatic read_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issue one instruction from a negedge and wait for its retirement.
  task automatic issue(input string tag, input logic [15:0] ins);
    int k;
    k = 0;
    while (!instr_ready && k < 8) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check({tag, "_ready"}, 16'(instr_ready), 16'd1);
    instr       = ins;
    instr_valid = 1'b1;
    predict(ins);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(posedge clk); @(negedge clk); k++;
    end
    check({tag, "_latency"}, 16'(k), 16'd3);
    if (done) compare_retire(tag);
    else void'(sb_q.pop_front());
  endtask

  initial begin
    int accepts;
    int dones;
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 3'd0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 16'(instr_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_wb", wb_data, 16'h0000);
    check("rst_sel", 16'(alu_op_select), 16'd0);
    check("rst_op_a", alu_op_a, 16'h0000);
    rst = 1'b0;
    #1;
    check("idle_ready", 16'(instr_ready), 16'd1);
    read_reg("rst_r3", 3'd3, 16'h0000);

    // LDI / ADD chain with back-to-back dependency
    issue("ldi_r1", encode(3'b101, 3'd1, 3'd0, 7'h7F));
    issue("ldi_r2", encode(3'b101, 3'd2, 3'd0, 7'h01));
    issue("add_r3", encode(3'b000, 3'd3, 3'd1, {3'd2, 4'h0}));
    read_reg("dbg_r3", 3'd3, 16'h0080);

    // Wrap-around subtract and NAND
    issue("sub_r4", encode(3'b001, 3'd4, 3'd0, {3'd2, 4'h0}));
    read_reg("dbg_r4", 3'd4, 16'hFFFF);
    issue("nand_r5", encode(3'b010, 3'd5, 3'd4, {3'd4, 4'h0}));
    read_reg("dbg_r5", 3'd5, 16'h0000);

    // Writes to r0 are discarded
    issue("add_r0", encode(3'b000, 3'd0, 3'd1, {3'd2, 4'h0}));
    check("add_r0_wb_const", wb_data, 16'h0080);
    read_reg("dbg_r0", 3'd0, 16'h0000);

    // Illegal opcode
    issue("illegal", encode(3'b111, 3'd2, 3'd1, {3'd3, 4'h0}));
    check("illegal_sel", 16'(alu_op_select), 16'(3'b011));
    for (int r = 0; r < 8; r++) read_reg($sformatf("illegal_r%0d", r), 3'(r), mreg[r]);

    // instr_valid held high for 12 cycles: ADD r7, r7, r1
    accepts     = 0;
    dones       = 0;
    instr       = encode(3'b000, 3'd7, 3'd7, {3'd1, 4'h0});
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("held_ready_vs_busy", 16'(instr_ready), 16'(!busy));
      if (done) begin dones++; compare_retire("held"); end
      if (instr_ready) begin accepts++; predict(instr); end
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    if (done) begin dones++; compare_retire("held"); end
    check("held_accepts", 16'(accepts), 16'd3);
    check("held_dones", 16'(dones), 16'd3);
    read_reg("held_r7", 3'd7, 16'h017D);

    // Reset during EXEC of LDI r6, #0x55
    instr       = encode(3'b101, 3'd6, 3'd0, 7'h55);
    instr_valid = 1'b1;
    @(posedge clk);            // accept -> READ
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);            // READ -> EXEC
    @(negedge clk);
    check("abort_in_exec_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    @(posedge clk);            // reset edge while in EXEC
    @(negedge clk);
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    check("abort_done", 16'(done), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", 16'(instr_ready), 16'd1);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_no_done", 16'(dones), 16'd0);
    read_reg("abort_r6", 3'd6, 16'h0000);
    read_reg("abort_r1", 3'd1, 16'h0000);
    check("abort_wb", wb_data, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
